subneg_core: RTL and testbench
==============================

SUBNEG_CORE -- requirements
Module: subneg_core

Interface
REQ-001 Parameter DW, default 8: data and address width in bits; legal range 4..16.
REQ-002 Parameter WAIT, default 0: extra SRAM read wait cycles inserted before each capture; legal range 0..7.
REQ-003 Parameter MODE, default 0: branch rule. 0 = SUBNEG, branch if A > B unsigned. 1 = SUBLEQ, branch if A >= B unsigned.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  level; when high the core starts the next instruction from IDLE.
REQ-007 bus_in  in  DW  shared address/data bus, read path.
REQ-008 bus_out  out  DW  shared bus, drive path (address to latch, write data to SRAM).
REQ-009 bus_oe  out  DW  bus drive enable; equals DW copies of mem_oe_n.
REQ-010 latch_le  out  1  external address latch enable; high = transparent.
REQ-011 mem_oe_n  out  1  SRAM output enable, active low.
REQ-012 mem_we_n  out  1  SRAM write enable, active low.
REQ-013 in_data  in  DW  input port; read when the effective address is all-ones.
REQ-014 out_data  out  DW  output port register; written when the write address is all-ones.
REQ-015 out_strobe  out  1  one-cycle pulse when out_data is updated.
REQ-016 halted  out  1  high once the core stops on a self-branch.
REQ-017 pc  out  DW  current program counter.

Function
REQ-018 States: IDLE, RD_A (addrA at PC), RD_B (addrB at PC+1), RD_C (addrC at PC+2), RD_VA (valA at addrA), RD_VB (valB at addrB), WR, HALT.
REQ-019 Each RD_* state runs phases ADDR, LATCH, OE, then WAIT wait cycles, then CAP: 4+WAIT cycles in total.
REQ-020 ADDR phase: latch_le=1, mem_oe_n=1, mem_we_n=1, bus_out=read address.
REQ-021 LATCH phase: latch_le=0. OE phase: mem_oe_n=0, which releases the bus (bus_oe=0).
REQ-022 CAP phase: the target register samples bus_in, or samples in_data when the read address is all-ones; that read does not assert mem_oe_n.
REQ-023 WR phases, 4 cycles total:
- ADDR: latch_le=1, bus_out=addrB.
- LATCH: latch_le=0.
- DATA: bus_out=valB-valA.
- STROBE: mem_we_n=0 for exactly one cycle, then mem_we_n returns to 1 on the following edge.
REQ-024 Result = (valB - valA) mod 2^DW. PC+1, PC+2 and PC+3 wrap mod 2^DW.
REQ-025 If addrB is all-ones, WR keeps mem_we_n=1; out_data <= result on the STROBE cycle and out_strobe pulses for that cycle.
REQ-026 Branch is decided in the WR STROBE cycle:
- Taken: PC <= addrC.
- Not taken: PC <= PC+3.
- Next state is IDLE.
REQ-027 If the branch is taken and addrC equals the current PC, the next state is HALT: halted=1 and the bus stays idle. Only reset leaves HALT. The WR for that instruction still completes.
REQ-028 IDLE with run=1 goes to RD_A on the next edge. IDLE with run=0 holds, with all strobes inactive. run is sampled only in IDLE.
REQ-029 Instruction latency is 5*(4+WAIT)+4+1 cycles including IDLE: 25 cycles at WAIT=0.
REQ-030 mem_oe_n and mem_we_n are never low in the same cycle. latch_le is never high while mem_oe_n=0.

Reset
REQ-031 reset sampled high on any edge, in any state, forces on that edge:
- state=IDLE, pc=0, halted=0, out_data=0, out_strobe=0, bus_out=0.
- latch_le=1, mem_oe_n=1, mem_we_n=1, bus_oe=all-ones.
REQ-032 reset overrides every state transition. A write interrupted by reset never asserts mem_we_n.
REQ-033 All outputs are registered and glitch-free.

Verification (DW=8, WAIT=0, MODE=0 unless noted)
REQ-034 Memory [0]=10,[1]=11,[2]=6,[10]=3,[11]=5; run=1 -> mem[11] becomes 2, branch not taken, pc=3 after 25 cycles, mem_we_n low for exactly 1 cycle.
REQ-035 [10]=7,[11]=5 -> mem[11]=0xFE, pc=6. With MODE=1 and [10]=5,[11]=5 -> mem[11]=0, pc=6.
REQ-036 addrB=0xFF, valA=0x01, in_data=0x09 -> out_data=0x08, out_strobe 1 cycle, mem_we_n stays 1 for the whole instruction.
REQ-037 Self-branch: instruction at 0 with addrC=0 and A>B -> halted=1 at cycle 25, no further latch_le/mem_oe_n activity, and run toggling has no effect until reset.
REQ-038 Assert reset during the WR DATA cycle -> mem_we_n never goes low, all outputs take reset values on that edge, and the next instruction fetch begins at address 0.
REQ-039 WAIT=3: instruction takes 40 cycles, each read holds mem_oe_n low for 4 cycles, and the REQ-034 results are unchanged.

Source files
------------

// File: rtl/subneg_core.sv
// subneg_core: one-instruction (SUBNEG/SUBLEQ) CPU driving a multiplexed
// address/data bus through an external address latch into an SRAM.
// Each instruction reads addrA, addrB and addrC from PC..PC+2, then valA and
// valB. It writes valB-valA back to addrB, or to the output port when addrB
// is all-ones, and then branches.
//
// Handshake: run is a plain level with no ready. It is sampled only in IDLE,
// and one instruction starts per IDLE cycle in which run is high. The core
// returns to IDLE after every instruction, so holding run high executes
// instructions back to back. dbg_state mirrors the FSM state.
module subneg_core #(
  parameter int DW   = 8,
  parameter int WAIT = 0,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic [DW-1:0] bus_oe,
  output logic          latch_le,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_strobe,
  output logic          halted,
  output logic [DW-1:0] pc,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_RD_C  = 3'd3,
    S_RD_VA = 3'd4,
    S_RD_VB = 3'd5,
    S_WR    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  // Read phases: 0 ADDR, 1 LATCH, 2 OE, 3..2+WAIT wait, 3+WAIT CAP.
  // Data is sampled on the edge that ends the last OE/wait cycle, while the
  // SRAM still drives the bus. CAP then parks the bus for the next address.
  localparam logic [3:0]    PH_CAP = 4'(3 + WAIT);
  localparam logic [3:0]    PH_SMP = 4'(2 + WAIT);
  localparam logic [DW-1:0] ONES   = '1;

  state_t        state;
  logic [3:0]    ph;
  logic [DW-1:0] addr_a, addr_b, addr_c, val_a, val_b;

  logic [DW-1:0] pc_p1, pc_p2, pc_p3, result;
  logic [DW-1:0] rd_addr, next_addr, cap_val;
  state_t        next_rd;
  logic          take, self_br;

  assign pc_p1     = pc + DW'(1);
  assign pc_p2     = pc + DW'(2);
  assign pc_p3     = pc + DW'(3);
  assign result    = val_b - val_a;
  assign take      = (MODE == 1) ? (val_a >= val_b) : (val_a > val_b);
  assign self_br   = take && (addr_c == pc);
  assign cap_val   = (rd_addr == ONES) ? in_data : bus_in;
  assign dbg_state = state;

  // Current read address, the following state, and that state's address.
  always_comb begin
    rd_addr   = addr_b;
    next_rd   = S_WR;
    next_addr = addr_b;
    case (state)
      S_RD_A:  begin rd_addr = pc;     next_rd = S_RD_B;  next_addr = pc_p1;  end
      S_RD_B:  begin rd_addr = pc_p1;  next_rd = S_RD_C;  next_addr = pc_p2;  end
      S_RD_C:  begin rd_addr = pc_p2;  next_rd = S_RD_VA; next_addr = addr_a; end
      S_RD_VA: begin rd_addr = addr_a; next_rd = S_RD_VB; next_addr = addr_b; end
      S_RD_VB: begin rd_addr = addr_b; next_rd = S_WR;    next_addr = addr_b; end
      default: begin rd_addr = addr_b; next_rd = S_WR;    next_addr = addr_b; end
    endcase
  end

  // Instruction FSM; every bus and port output is set on the edge that
  // enters the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ph         <= '0;
      pc         <= '0;
      halted     <= 1'b0;
      out_data   <= '0;
      out_strobe <= 1'b0;
      bus_out    <= '0;
      bus_oe     <= '1;
      latch_le   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_c     <= '0;
      val_a      <= '0;
      val_b      <= '0;
    end else begin
      out_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_RD_A;
            ph       <= '0;
            latch_le <= 1'b1;
            bus_out  <= pc;
          end
        end
        S_RD_A, S_RD_B, S_RD_C, S_RD_VA, S_RD_VB: begin
          if (ph == 4'd0) begin
            ph       <= 4'd1;
            latch_le <= 1'b0;
          end else if (ph == 4'd1) begin
            ph <= 4'd2;
            // The input port is not behind the SRAM, so keep it disabled.
            if (rd_addr != ONES) begin
              mem_oe_n <= 1'b0;
              bus_oe   <= '0;
            end
          end else if (ph < PH_SMP) begin
            ph <= 4'(ph + 4'd1);
          end else if (ph == PH_SMP) begin
            ph       <= PH_CAP;
            mem_oe_n <= 1'b1;
            bus_oe   <= '1;
            case (state)
              S_RD_A:  addr_a <= cap_val;
              S_RD_B:  addr_b <= cap_val;
              S_RD_C:  addr_c <= cap_val;
              S_RD_VA: val_a  <= cap_val;
              default: val_b  <= cap_val;
            endcase
          end else begin
            state    <= next_rd;
            ph       <= '0;
            latch_le <= 1'b1;
            bus_out  <= next_addr;
          end
        end
        S_WR: begin
          if (ph == 4'd0) begin
            ph       <= 4'd1;
            latch_le <= 1'b0;
          end else if (ph == 4'd1) begin
            ph      <= 4'd2;
            bus_out <= result;
          end else if (ph == 4'd2) begin
            ph <= 4'd3;
            if (addr_b == ONES) begin
              out_data   <= result;
              out_strobe <= 1'b1;
            end else begin
              mem_we_n <= 1'b0;
            end
          end else begin
            ph       <= '0;
            mem_we_n <= 1'b1;
            latch_le <= 1'b1;
            pc       <= take ? addr_c : pc_p3;
            halted   <= self_br;
            state    <= self_br ? S_HALT : S_IDLE;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subneg_core.sv
// Bench for subneg_core: three instances (0: default, 1: MODE=1, 2: WAIT=3),
// each with its own address latch and 256-byte SRAM model.
module tb_subneg_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_v [3];
  logic [7:0] in_data;

  logic [7:0] bus_in_w [3];
  logic [7:0] bus_out_w [3];
  logic [7:0] bus_oe_w [3];
  logic [7:0] out_data_w [3];
  logic [7:0] pc_w [3];
  logic       le_w [3];
  logic       oe_w [3];
  logic       we_w [3];
  logic       stb_w [3];
  logic       halt_w [3];
  logic [2:0] dbg_w [3];

  logic [7:0] mem [3][256];
  logic [7:0] lat [3];
  logic       ld_en, clr;
  int         ld_idx;
  logic [7:0] ld_addr, ld_data;

  int n_cmp = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    subneg_core #(.DW(8), .WAIT(g == 2 ? 3 : 0), .MODE(g == 1 ? 1 : 0)) u_dut (
      .clk(clk), .reset(reset), .run(run_v[g]),
      .bus_in(bus_in_w[g]), .bus_out(bus_out_w[g]), .bus_oe(bus_oe_w[g]),
      .latch_le(le_w[g]), .mem_oe_n(oe_w[g]), .mem_we_n(we_w[g]),
      .in_data(in_data), .out_data(out_data_w[g]), .out_strobe(stb_w[g]),
      .halted(halt_w[g]), .pc(pc_w[g]), .dbg_state(dbg_w[g])
    );
    assign bus_in_w[g] = !oe_w[g] ? mem[g][lat[g]] : bus_out_w[g];
  end

  // latch + SRAM models, plus the bench's load/clear port into the SRAMs
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (le_w[g]) lat[g] <= bus_out_w[g];
      if (!we_w[g]) mem[g][lat[g]] <= bus_out_w[g];
    end
    if (clr)
      for (int g = 0; g < 3; g++)
        for (int a = 0; a < 256; a++) mem[g][a] <= 8'h00;
    if (ld_en) mem[ld_idx][ld_addr] <= ld_data;
  end

  // driver tasks
  task automatic poke(input int idx, input logic [7:0] a, input logic [7:0] d);
    ld_idx = idx; ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fresh_start();
    reset = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; clr = 1'b0;
  endtask

  task automatic load_instr(input int idx, input logic [7:0] at, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
    poke(idx, at, a);
    poke(idx, at + 8'd1, b);
    poke(idx, at + 8'd2, c);
  endtask

  // Runs until pc moves, halted rises, or limit cycles elapse.
  task automatic run_instr(input int idx, input int limit, output int cyc,
                           output int we_low, output int stb, output int oe_max,
                           output int viol, output logic [7:0] first_addr,
                           output bit tmo);
    logic [7:0] pc0;
    int oe_run;
    bit done;
    pc0 = pc_w[idx];
    cyc = 0; we_low = 0; stb = 0; oe_max = 0; viol = 0; oe_run = 0; done = 0;
    first_addr = 8'hxx;
    run_v[idx] = 1'b1;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) first_addr = bus_out_w[idx];
      if (!we_w[idx]) we_low++;
      if (stb_w[idx]) stb++;
      if (!oe_w[idx]) oe_run++; else oe_run = 0;
      if (oe_run > oe_max) oe_max = oe_run;
      if ((!oe_w[idx] && !we_w[idx]) || (le_w[idx] && !oe_w[idx]) ||
          (bus_oe_w[idx] !== {8{oe_w[idx]}})) viol++;
      done = (pc_w[idx] !== pc0) || halt_w[idx];
    end
    run_v[idx] = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_cmp++; if (pc_w[g] !== 8'h00) begin n_fail++; $display("FAIL reset_pc[%0d]: got %h want 00", g, pc_w[g]); end
      n_cmp++; if (bus_out_w[g] !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out[%0d]: got %h want 00", g, bus_out_w[g]); end
      n_cmp++; if (bus_oe_w[g] !== 8'hff) begin n_fail++; $display("FAIL reset_bus_oe[%0d]: got %h want ff", g, bus_oe_w[g]); end
      n_cmp++; if ({le_w[g], oe_w[g], we_w[g]} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes[%0d]: got %b want 111", g, {le_w[g], oe_w[g], we_w[g]}); end
      n_cmp++; if ({halt_w[g], stb_w[g]} !== 2'b00) begin n_fail++; $display("FAIL reset_flags[%0d]: got %b want 00", g, {halt_w[g], stb_w[g]}); end
      n_cmp++; if (out_data_w[g] !== 8'h00) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h want 00", g, out_data_w[g]); end
    end
    reset = 1'b0;
    // run low: core must stay idle
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if ({dbg_w[0], le_w[0], oe_w[0], we_w[0]} !== 6'b000111) begin n_fail++; $display("FAIL idle_hold: got %b want 000111", {dbg_w[0], le_w[0], oe_w[0], we_w[0]}); end
  endtask

  task automatic test_not_taken();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    load_instr(0, 8'd0, 8'd10, 8'd11, 8'd6);
    poke(0, 8'd10, 8'd3); poke(0, 8'd11, 8'd5);
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (tmo) begin n_fail++; $display("FAIL nt_timeout: got timeout want pc change"); end
    n_cmp++; if (cyc != 25) begin n_fail++; $display("FAIL nt_latency: got %0d want 25", cyc); end
    n_cmp++; if (mem[0][11] !== 8'h02) begin n_fail++; $display("FAIL nt_result: got %h want 02", mem[0][11]); end
    n_cmp++; if (pc_w[0] !== 8'h03) begin n_fail++; $display("FAIL nt_pc: got %h want 03", pc_w[0]); end
    n_cmp++; if (wl != 1) begin n_fail++; $display("FAIL nt_we_pulse: got %0d want 1", wl); end
    n_cmp++; if (vi != 0) begin n_fail++; $display("FAIL nt_bus_rules: got %0d want 0", vi); end
    n_cmp++; if (fa !== 8'h00) begin n_fail++; $display("FAIL nt_first_addr: got %h want 00", fa); end
  endtask

  task automatic test_back_to_back();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    // continues from test_not_taken: pc = 3
    load_instr(0, 8'd3, 8'd12, 8'd13, 8'd0);
    poke(0, 8'd12, 8'd1); poke(0, 8'd13, 8'd4);
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (fa !== 8'h03) begin n_fail++; $display("FAIL b2b_first_addr: got %h want 03", fa); end
    n_cmp++; if (mem[0][13] !== 8'h03) begin n_fail++; $display("FAIL b2b_result: got %h want 03", mem[0][13]); end
    n_cmp++; if (pc_w[0] !== 8'h06) begin n_fail++; $display("FAIL b2b_pc: got %h want 06", pc_w[0]); end
  endtask

  task automatic test_taken();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    load_instr(0, 8'd0, 8'd10, 8'd11, 8'd6);
    poke(0, 8'd10, 8'd7); poke(0, 8'd11, 8'd5);
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (mem[0][11] !== 8'hfe) begin n_fail++; $display("FAIL tk_result: got %h want fe", mem[0][11]); end
    n_cmp++; if (pc_w[0] !== 8'h06) begin n_fail++; $display("FAIL tk_pc: got %h want 06", pc_w[0]); end
    n_cmp++; if (halt_w[0] !== 1'b0) begin n_fail++; $display("FAIL tk_halted: got %b want 0", halt_w[0]); end
  endtask

  task automatic test_subleq();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    load_instr(1, 8'd0, 8'd10, 8'd11, 8'd6);
    poke(1, 8'd10, 8'd5); poke(1, 8'd11, 8'd5);
    run_instr(1, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (mem[1][11] !== 8'h00) begin n_fail++; $display("FAIL leq_result: got %h want 00", mem[1][11]); end
    n_cmp++; if (pc_w[1] !== 8'h06) begin n_fail++; $display("FAIL leq_pc: got %h want 06", pc_w[1]); end
  endtask

  task automatic test_out_port();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    in_data = 8'h09;
    load_instr(0, 8'd0, 8'd10, 8'hff, 8'd3);
    poke(0, 8'd10, 8'h01);
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (out_data_w[0] !== 8'h08) begin n_fail++; $display("FAIL op_out_data: got %h want 08", out_data_w[0]); end
    n_cmp++; if (st != 1) begin n_fail++; $display("FAIL op_strobe: got %0d want 1", st); end
    n_cmp++; if (wl != 0) begin n_fail++; $display("FAIL op_no_write: got %0d want 0", wl); end
    n_cmp++; if (pc_w[0] !== 8'h03) begin n_fail++; $display("FAIL op_pc: got %h want 03", pc_w[0]); end
    n_cmp++; if (mem[0][255] !== 8'h00) begin n_fail++; $display("FAIL op_mem_ff: got %h want 00", mem[0][255]); end
    in_data = 8'h00;
  endtask

  task automatic test_self_branch();
    int cyc, wl, st, om, vi, chg; logic [7:0] fa; bit tmo;
    logic le_p, oe_p;
    fresh_start();
    load_instr(0, 8'd0, 8'd10, 8'd11, 8'd0);
    poke(0, 8'd10, 8'd7); poke(0, 8'd11, 8'd5);
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (!halt_w[0] || cyc != 25) begin n_fail++; $display("FAIL sb_halt: got halted=%b at %0d want 1 at 25", halt_w[0], cyc); end
    n_cmp++; if (mem[0][11] !== 8'hfe) begin n_fail++; $display("FAIL sb_write: got %h want fe", mem[0][11]); end
    chg = 0; le_p = le_w[0]; oe_p = oe_w[0];
    for (int i = 0; i < 20; i++) begin
      run_v[0] = i[0];
      @(posedge clk); #1;
      if (le_w[0] !== le_p || oe_w[0] !== oe_p || !we_w[0]) chg++;
      le_p = le_w[0]; oe_p = oe_w[0];
    end
    run_v[0] = 1'b0;
    n_cmp++; if (chg != 0) begin n_fail++; $display("FAIL sb_bus_quiet: got %0d changes want 0", chg); end
    n_cmp++; if (halt_w[0] !== 1'b1 || pc_w[0] !== 8'h00) begin n_fail++; $display("FAIL sb_stay: got halted=%b pc=%h want 1/00", halt_w[0], pc_w[0]); end
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    n_cmp++; if (halt_w[0] !== 1'b0) begin n_fail++; $display("FAIL sb_reset: got %b want 0", halt_w[0]); end
  endtask

  task automatic test_reset_mid_write();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    load_instr(0, 8'd0, 8'd10, 8'd11, 8'd6);
    poke(0, 8'd10, 8'd3); poke(0, 8'd11, 8'd5);
    run_instr(0, 23, cyc, wl, st, om, vi, fa, tmo);  // now in WR DATA
    n_cmp++; if (bus_out_w[0] !== 8'h02) begin n_fail++; $display("FAIL rw_data_phase: got %h want 02", bus_out_w[0]); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({le_w[0], oe_w[0], we_w[0]} !== 3'b111) begin n_fail++; $display("FAIL rw_strobes: got %b want 111", {le_w[0], oe_w[0], we_w[0]}); end
    n_cmp++; if (pc_w[0] !== 8'h00 || bus_out_w[0] !== 8'h00 || bus_oe_w[0] !== 8'hff) begin n_fail++; $display("FAIL rw_regs: got pc=%h bus=%h oe=%h want 00/00/ff", pc_w[0], bus_out_w[0], bus_oe_w[0]); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wl != 0 || mem[0][11] !== 8'h05) begin n_fail++; $display("FAIL rw_no_write: got we_low=%0d mem=%h want 0/05", wl, mem[0][11]); end
    run_instr(0, 60, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (fa !== 8'h00 || pc_w[0] !== 8'h03) begin n_fail++; $display("FAIL rw_refetch: got addr=%h pc=%h want 00/03", fa, pc_w[0]); end
  endtask

  task automatic test_wait3();
    int cyc, wl, st, om, vi; logic [7:0] fa; bit tmo;
    fresh_start();
    load_instr(2, 8'd0, 8'd10, 8'd11, 8'd6);
    poke(2, 8'd10, 8'd3); poke(2, 8'd11, 8'd5);
    run_instr(2, 100, cyc, wl, st, om, vi, fa, tmo);
    n_cmp++; if (cyc != 40) begin n_fail++; $display("FAIL w3_latency: got %0d want 40", cyc); end
    n_cmp++; if (om != 4) begin n_fail++; $display("FAIL w3_oe_len: got %0d want 4", om); end
    n_cmp++; if (mem[2][11] !== 8'h02 || pc_w[2] !== 8'h03) begin n_fail++; $display("FAIL w3_result: got mem=%h pc=%h want 02/03", mem[2][11], pc_w[2]); end
    n_cmp++; if (vi != 0 || wl != 1) begin n_fail++; $display("FAIL w3_bus_rules: got viol=%0d we_low=%0d want 0/1", vi, wl); end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; ld_en = 1'b0; ld_idx = 0; ld_addr = 8'h00; ld_data = 8'h00;
    in_data = 8'h00;
    for (int g = 0; g < 3; g++) begin run_v[g] = 1'b0; lat[g] = 8'h00; end
    @(posedge clk); #1;
    test_reset();
    test_not_taken();
    test_back_to_back();
    test_taken();
    test_subleq();
    test_out_port();
    test_self_branch();
    test_reset_mid_write();
    test_wait3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
